// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch front end: bus layout, reset PC and helpers.
package if_stage_pkg;

    localparam int          FS_TO_DS_BUS_WD = 34;
    localparam logic [31:0] RESET_PC        = 32'h1c000000;
    localparam int          BUS_VALID_BIT   = 33;
    localparam int          BUS_ADEF_BIT    = 32;

    typedef struct packed {
        logic        pc_valid;
        logic        excp_adef;
        logic [31:0] pc;
    } fs2_bus_t;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_pc_gen.sv
// Next-PC selection for fs1 plus the pending-redirect register that parks a branch
// target arriving while the PC is stalled.
module if_stage_pc_gen
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC_VAL = RESET_PC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        stall_pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] pc,
    output logic        br_redirect,
    output logic        redirect
);

    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        br_redirect   = 1'b0;
        if (flush) begin
            pc_d         = flush_pc;
            pend_valid_d = 1'b0;
        end else if (stall_pc) begin
            // A branch seen under stall is parked until the PC is free to move.
            if (br_taken) begin
                pend_valid_d  = 1'b1;
                pend_target_d = br_target;
            end
        end else if (br_taken) begin
            pc_d         = br_target;
            pend_valid_d = 1'b0;
            br_redirect  = 1'b1;
        end else if (pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
            br_redirect  = 1'b1;
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q          <= RESET_PC_VAL;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc       = pc_q;
    assign redirect = flush | br_redirect;

endmodule

// File: rtl/if_stage.sv
// Two-stage instruction fetch: fs1 drives the SRAM address, fs2 tags the returning data for id.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC_VAL = RESET_PC
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic [31:0]                flush_pc,
    input  logic [5:0]                 stall,
    input  logic                       br_taken,
    input  logic [31:0]                br_target,
    output logic                       inst_sram_en,
    output logic [3:0]                 inst_sram_we,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]                perf_fetch_cnt,
    output logic [31:0]                perf_redirect_cnt,
`endif
    output logic [FS_TO_DS_BUS_WD-1:0] fs2_to_ds_bus
);

    logic [31:0] fs1_pc;
    logic        fs1_adef;
    logic        br_redirect;
    logic        redirect;
    fs2_bus_t    fs2_q, fs2_d;
    logic        fs2_load_valid;
    logic        unused_stall_bits;

    if_stage_pc_gen #(.RESET_PC_VAL(RESET_PC_VAL)) u_pc_gen (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .stall_pc    (stall[0]),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .pc          (fs1_pc),
        .br_redirect (br_redirect),
        .redirect    (redirect)
    );

    assign fs1_adef = pc_misaligned(fs1_pc);

    // Any applied branch redirect (direct or pending) means fs1 holds a wrong-path PC.
    always_comb begin
        fs2_d          = fs2_q;
        fs2_load_valid = 1'b0;
        if (flush) begin
            fs2_d = '0;
        end else if (stall[1]) begin
            fs2_d = fs2_q;
        end else if (stall[0] || br_redirect) begin
            fs2_d = '0;
        end else begin
            fs2_d.pc_valid  = 1'b1;
            fs2_d.excp_adef = fs1_adef;
            fs2_d.pc        = fs1_pc;
            fs2_load_valid  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fs2_q <= '0;
        end else begin
            fs2_q <= fs2_d;
        end
    end

    assign inst_sram_en      = resetn & ~fs1_adef;
    assign inst_sram_we      = 4'b0000;
    assign inst_sram_addr    = fs1_pc;
    assign inst_sram_wdata   = 32'd0;
    assign fs2_to_ds_bus     = fs2_q;
    assign unused_stall_bits = ^stall[5:2];

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_redir_q, perf_redir_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + {31'd0, fs2_load_valid};
        perf_redir_d = perf_redir_q + {31'd0, redirect};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_fetch_q <= 32'd0;
            perf_redir_q <= 32'd0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_redir_q <= perf_redir_d;
        end
    end

    assign perf_fetch_cnt    = perf_fetch_q;
    assign perf_redirect_cnt = perf_redir_q;
`else
    logic unused_perf;
    assign unused_perf = fs2_load_valid ^ redirect;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage: sequential fetch, branch, stalled branch,
// flush over branch, ADEF and async reset; perf counters when IF_PERF_CNT_EN is defined.
module tb_if_stage;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [33:0] fs2_to_ds_bus;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_redirect_cnt;
`endif

    int checks;
    int errors;

    if_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .stall           (stall),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
`ifdef IF_PERF_CNT_EN
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_redirect_cnt (perf_redirect_cnt),
`endif
        .fs2_to_ds_bus   (fs2_to_ds_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [33:0] observed,
                               input logic [33:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [33:0] bus(input logic v, input logic a, input logic [31:0] pc);
        return {v, a, pc};
    endfunction

    task automatic checkFetch(input string tag, input logic [31:0] addr,
                              input logic en, input logic [33:0] b);
        checkOutput({tag, "_addr"}, {2'b00, inst_sram_addr}, {2'b00, addr});
        checkOutput({tag, "_en"},   {33'd0, inst_sram_en},   {33'd0, en});
        checkOutput({tag, "_bus"},  fs2_to_ds_bus,           b);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        resetn    = 1'b0;
        flush     = 1'b0;
        flush_pc  = 32'd0;
        stall     = 6'd0;
        br_taken  = 1'b0;
        br_target = 32'd0;

        #12;
        checkFetch("reset", 32'h1c000000, 1'b0, 34'd0);
        checkOutput("we_zero", {30'd0, inst_sram_we}, 34'd0);
        checkOutput("wdata_zero", {2'b00, inst_sram_wdata}, 34'd0);

        step();
        resetn = 1'b1;
        #1;
        checkFetch("seq0", 32'h1c000000, 1'b1, 34'd0);
        step();
        checkFetch("seq1", 32'h1c000004, 1'b1, bus(1'b1, 1'b0, 32'h1c000000));
        step();
        checkFetch("seq2", 32'h1c000008, 1'b1, bus(1'b1, 1'b0, 32'h1c000004));
        step();
        step();
        checkFetch("seq4", 32'h1c000010, 1'b1, bus(1'b1, 1'b0, 32'h1c00000c));

        br_taken  = 1'b1;
        br_target = 32'h1c000100;
        step();
        br_taken = 1'b0;
        checkFetch("br", 32'h1c000100, 1'b1, 34'd0);
        step();
        checkFetch("br_after", 32'h1c000104, 1'b1, bus(1'b1, 1'b0, 32'h1c000100));

        stall = 6'b000011;
        step();
        checkFetch("stall1", 32'h1c000104, 1'b1, bus(1'b1, 1'b0, 32'h1c000100));
        br_taken  = 1'b1;
        br_target = 32'h1c000200;
        step();
        br_taken = 1'b0;
        checkFetch("stall2", 32'h1c000104, 1'b1, bus(1'b1, 1'b0, 32'h1c000100));
        step();
        checkOutput("stall3_addr", {2'b00, inst_sram_addr}, {2'b00, 32'h1c000104});
        stall = 6'd0;
        step();
        checkOutput("pend_apply_addr", {2'b00, inst_sram_addr}, {2'b00, 32'h1c000200});
        step();
        checkFetch("pend_after", 32'h1c000204, 1'b1, bus(1'b1, 1'b0, 32'h1c000200));
        step();
        checkOutput("pend_clear_addr", {2'b00, inst_sram_addr}, {2'b00, 32'h1c000208});

        stall     = 6'b000001;
        br_taken  = 1'b1;
        br_target = 32'h1c000300;
        step();
        checkFetch("stall0_bubble", 32'h1c000208, 1'b1, 34'd0);
        stall     = 6'd0;
        flush     = 1'b1;
        flush_pc  = 32'h1c008000;
        br_target = 32'h1c000400;
        step();
        flush    = 1'b0;
        br_taken = 1'b0;
        checkFetch("flush", 32'h1c008000, 1'b1, 34'd0);
        step();
        checkFetch("flush_after", 32'h1c008004, 1'b1, bus(1'b1, 1'b0, 32'h1c008000));

        flush    = 1'b1;
        flush_pc = 32'h1c000102;
        step();
        flush = 1'b0;
        checkFetch("adef", 32'h1c000102, 1'b0, 34'd0);
        step();
        checkFetch("adef_bus", 32'h1c000106, 1'b0, bus(1'b1, 1'b1, 32'h1c000102));

        #2;
        resetn = 1'b0;
        #1;
        checkFetch("async_rst", 32'h1c000000, 1'b0, 34'd0);

`ifdef IF_PERF_CNT_EN
        checkOutput("perf_rst_fetch", {2'b00, perf_fetch_cnt}, 34'd0);
        checkOutput("perf_rst_redir", {2'b00, perf_redirect_cnt}, 34'd0);
        step();
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) step();
        br_taken  = 1'b1;
        br_target = 32'h1c000100;
        step();
        br_taken = 1'b0;
        checkOutput("perf_fetch", {2'b00, perf_fetch_cnt}, 34'd10);
        checkOutput("perf_redir", {2'b00, perf_redirect_cnt}, 34'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
